// File: rtl/dram_ctrl.sv
// Initiator-side controller for the 8x8 refresh-based DRAM model: single-beat
// client reads/writes over valid/ready, plus an owned periodic all-row refresh burst.
module dram_ctrl #(
    parameter int ADDR_W           = 3,
    parameter int DATA_W           = 8,
    parameter int REFRESH_INTERVAL = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_we,
    output logic              mem_refresh,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              refresh_busy,
    output logic              ref_overrun
);

    localparam int ROWS  = 2 ** ADDR_W;
    localparam int TMR_W = $clog2(REFRESH_INTERVAL);

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REFRESH_INTERVAL - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [ADDR_W:0]  ROW_LAST   = (ADDR_W + 1)'(ROWS - 1);
    localparam logic [ADDR_W:0]  ROW_ONE    = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_WAIT,
        REF
    } state_e;

    state_e              state_q,       state_d;
    logic [ADDR_W-1:0]   addr_q,        addr_d;
    logic [DATA_W-1:0]   wdata_q,       wdata_d;
    logic                rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                ref_pending_q, ref_pending_d;
    logic                ref_overrun_q, ref_overrun_d;
    logic [ADDR_W:0]     row_cnt_q,     row_cnt_d;
    logic [TMR_W-1:0]    timer_q,       timer_d;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        ref_pending_d = ref_pending_q;
        ref_overrun_d = ref_overrun_q;
        row_cnt_d     = row_cnt_q;
        timer_d       = timer_q - TMR_ONE;

        case (state_q)
            IDLE: begin
                if (ref_pending_q) begin
                    state_d       = REF;
                    ref_pending_d = 1'b0;
                    row_cnt_d     = '0;
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_we ? WR : RD;
                end
            end
            WR:      state_d = IDLE;
            RD:      state_d = RD_WAIT;
            RD_WAIT: begin
                rsp_rdata_d = mem_dout;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            REF: begin
                row_cnt_d = row_cnt_q + ROW_ONE;
                if (row_cnt_q == ROW_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Expiry is applied last so a request raised on the same edge that
        // consumes the previous one is not lost.
        if (timer_q == '0) begin
            timer_d       = TMR_RELOAD;
            ref_pending_d = 1'b1;
            if (ref_pending_q) begin
                ref_overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            ref_pending_q <= 1'b0;
            ref_overrun_q <= 1'b0;
            row_cnt_q     <= '0;
            timer_q       <= TMR_RELOAD;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            ref_pending_q <= ref_pending_d;
            ref_overrun_q <= ref_overrun_d;
            row_cnt_q     <= row_cnt_d;
            timer_q       <= timer_d;
        end
    end

    assign req_ready    = (state_q == IDLE) && !ref_pending_q;
    assign mem_we       = (state_q == WR);
    assign mem_refresh  = (state_q == REF);
    assign refresh_busy = (state_q == REF);
    assign mem_addr     = addr_q;
    assign mem_din      = wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign ref_overrun  = ref_overrun_q;

endmodule
